// File: rtl/rob_pkg.sv
// Shared reorder-buffer parameters and the per-entry record.
// The entry keeps dr_p and pc alongside the retire bookkeeping for trace visibility.
package rob_pkg;
    localparam int ROB_DEPTH = 16;
    localparam int IDX_W     = 4;
    localparam int PTR_W     = IDX_W + 1;
    localparam int PREG_W    = 6;
    localparam int NUM_PREG  = 64;
    localparam int NUM_CMPL  = 3;
    localparam int RETIRE_W  = 2;

    localparam logic [PREG_W:0] NO_OLD_PREG = 7'd64;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [PREG_W-1:0] dr_p;
        logic [PREG_W:0]   old_dr;
        logic [31:0]       pc;
    } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// Rename/FU-facing bus of the reorder buffer: allocation, completion and retire.
interface reorder_buffer_if;
    import rob_pkg::*;

    logic                      alloc_valid;
    logic [PREG_W-1:0]         alloc_dr_p;
    logic [PREG_W:0]           alloc_old_dr;
    logic [31:0]               alloc_pc;
    logic [IDX_W-1:0]          rob_num;
    logic                      rob_full;
    logic                      rob_empty;
    logic [NUM_CMPL-1:0]       cmpl_valid;
    logic [NUM_CMPL*IDX_W-1:0] cmpl_idx;
    logic [NUM_PREG-1:0]       retire_from_ROB;
    logic [1:0]                retire_cnt;

    modport master (
        output alloc_valid, alloc_dr_p, alloc_old_dr, alloc_pc,
        output cmpl_valid, cmpl_idx,
        input  rob_num, rob_full, rob_empty, retire_from_ROB, retire_cnt
    );

    modport slave (
        input  alloc_valid, alloc_dr_p, alloc_old_dr, alloc_pc,
        input  cmpl_valid, cmpl_idx,
        output rob_num, rob_full, rob_empty, retire_from_ROB, retire_cnt
    );
endinterface

// File: rtl/rob_retire_sel.sv
// Picks the in-order run of valid+done entries starting at head, up to RETIRE_W.
module rob_retire_sel
    import rob_pkg::*;
(
    input  logic [IDX_W-1:0]     head_idx,
    input  logic [ROB_DEPTH-1:0] valid_vec,
    input  logic [ROB_DEPTH-1:0] done_vec,
    output logic [1:0]           ret_n,
    output logic [RETIRE_W-1:0]  ret_en
);
    logic             stop;
    logic [IDX_W-1:0] slot_idx;

    always_comb begin
        ret_n    = '0;
        ret_en   = '0;
        stop     = 1'b0;
        slot_idx = '0;
        for (int s = 0; s < RETIRE_W; s++) begin
            slot_idx = head_idx + IDX_W'(s);
            if (!stop && valid_vec[slot_idx] && done_vec[slot_idx]) begin
                ret_en[s] = 1'b1;
                ret_n     = ret_n + 2'd1;
            end else begin
                stop = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at tail, marks done from FU tags, retires
// from head and pulses the freed previous mappings back to Rename.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    reorder_buffer_if.slave rob_bus
);
    rob_entry_t           rob_q [ROB_DEPTH];
    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [IDX_W-1:0]     head_idx;
    logic [IDX_W-1:0]     tail_idx;
    logic [ROB_DEPTH-1:0] valid_vec;
    logic [ROB_DEPTH-1:0] done_vec;
    logic [1:0]           ret_n;
    logic [RETIRE_W-1:0]  ret_en;
    logic [NUM_PREG-1:0]  free_vec;
    logic [NUM_PREG-1:0]  retire_vec_q;
    logic [1:0]           retire_cnt_q;
    logic [IDX_W-1:0]     free_idx;
    logic [PREG_W:0]      free_old;
    logic                 full;
    logic                 do_alloc;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign do_alloc = rob_bus.alloc_valid && !full;

    assign rob_bus.rob_num         = tail_idx;
    assign rob_bus.rob_full        = full;
    assign rob_bus.rob_empty       = (head_q == tail_q);
    assign rob_bus.retire_from_ROB = retire_vec_q;
    assign rob_bus.retire_cnt      = retire_cnt_q;

    always_comb begin
        valid_vec = '0;
        done_vec  = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            valid_vec[i] = rob_q[i].valid;
            done_vec[i]  = rob_q[i].done;
        end
    end

    rob_retire_sel u_retire_sel (
        .head_idx  (head_idx),
        .valid_vec (valid_vec),
        .done_vec  (done_vec),
        .ret_n     (ret_n),
        .ret_en    (ret_en)
    );

    // preg 0 and the "no previous mapping" tag never go back to the free pool
    always_comb begin
        free_vec = '0;
        free_idx = '0;
        free_old = '0;
        for (int s = 0; s < RETIRE_W; s++) begin
            free_idx = head_idx + IDX_W'(s);
            free_old = rob_q[free_idx].old_dr;
            if (ret_en[s] && free_old != NO_OLD_PREG && free_old != '0)
                free_vec[free_old[PREG_W-1:0]] = 1'b1;
        end
    end

    // Retiring entries are already done, so clearing after the completion
    // updates is safe; the allocated slot is never a retiring one (full blocks it).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ROB_DEPTH; i++)
                rob_q[i] <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            retire_vec_q <= '0;
            retire_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CMPL; k++) begin
                if (rob_bus.cmpl_valid[k] && rob_q[rob_bus.cmpl_idx[k*IDX_W +: IDX_W]].valid)
                    rob_q[rob_bus.cmpl_idx[k*IDX_W +: IDX_W]].done <= 1'b1;
            end
            for (int s = 0; s < RETIRE_W; s++) begin
                if (ret_en[s]) begin
                    rob_q[head_idx + IDX_W'(s)].valid <= 1'b0;
                    rob_q[head_idx + IDX_W'(s)].done  <= 1'b0;
                end
            end
            if (do_alloc)
                rob_q[tail_idx] <= '{valid:  1'b1,
                                     done:   1'b0,
                                     dr_p:   rob_bus.alloc_dr_p,
                                     old_dr: rob_bus.alloc_old_dr,
                                     pc:     rob_bus.alloc_pc};
            head_q       <= head_q + PTR_W'(ret_n);
            tail_q       <= tail_q + PTR_W'(do_alloc);
            retire_vec_q <= free_vec;
            retire_cnt_q <= ret_n;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against an
// in-order queue model of the buffer.
module tb_reorder_buffer;
    import rob_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    reorder_buffer_if bus ();

    reorder_buffer dut (
        .clk     (clk),
        .rstn    (rstn),
        .rob_bus (bus)
    );

    typedef struct {
        int idx;
        int old;
        bit done;
    } m_ent_t;

    m_ent_t      mq[$];
    int          m_head;
    logic [63:0] exp_vec;
    int          exp_cnt;
    int          n_cmp;
    int          n_bad;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check_val("rob_num",    64'(bus.rob_num),   64'((m_head + mq.size()) % ROB_DEPTH));
        check_val("rob_full",   64'(bus.rob_full),  64'(mq.size() == ROB_DEPTH));
        check_val("rob_empty",  64'(bus.rob_empty), 64'(mq.size() == 0));
        check_val("retire_vec", bus.retire_from_ROB, exp_vec);
        check_val("retire_cnt", 64'(bus.retire_cnt), 64'(exp_cnt));
    endtask

    // One clock: check outputs, drive inputs, advance the model, cross the edge.
    task automatic cycle(input bit av, input int dr, input int od,
                         input bit [2:0] cv, input int c0, input int c1, input int c2);
        bit          full_pre;
        int          tail_pre;
        int          n;
        logic [63:0] vec;
        int          cs[3];
        m_ent_t      e;

        check_outputs();
        bus.alloc_valid  = av;
        bus.alloc_dr_p   = 6'(dr);
        bus.alloc_old_dr = 7'(od);
        bus.alloc_pc     = $urandom;
        bus.cmpl_valid   = cv;
        bus.cmpl_idx     = {4'(c2), 4'(c1), 4'(c0)};

        cs[0] = c0; cs[1] = c1; cs[2] = c2;
        full_pre = (mq.size() == ROB_DEPTH);
        tail_pre = (m_head + mq.size()) % ROB_DEPTH;
        n   = 0;
        vec = '0;
        while (n < RETIRE_W && mq.size() > 0 && mq[0].done) begin
            e = mq.pop_front();
            if (e.old != 64 && e.old != 0) vec[e.old] = 1'b1;
            m_head = (m_head + 1) % ROB_DEPTH;
            n++;
        end
        for (int k = 0; k < 3; k++)
            if (cv[k])
                foreach (mq[i])
                    if (mq[i].idx == cs[k] % ROB_DEPTH) mq[i].done = 1'b1;
        if (av && !full_pre) begin
            e.idx  = tail_pre;
            e.old  = od;
            e.done = 1'b0;
            mq.push_back(e);
        end
        exp_vec = vec;
        exp_cnt = n;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) cycle(0, 0, 0, 3'b000, 0, 0, 0);
    endtask

    task automatic alloc(input int dr, input int od);
        cycle(1, dr, od, 3'b000, 0, 0, 0);
    endtask

    task automatic complete_all();
        for (int i = 0; i < ROB_DEPTH; i += 3) cycle(0, 0, 0, 3'b111, i, i + 1, i + 2);
        idle(10);
    endtask

    task automatic do_reset();
        bus.alloc_valid = 1'b0;
        bus.cmpl_valid  = '0;
        rstn = 1'b0;
        #1;
        mq.delete();
        m_head  = 0;
        exp_vec = '0;
        exp_cnt = 0;
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        int od;
        int c[3];
        bit [2:0] cv;

        n_cmp = 0;
        n_bad = 0;
        bus.alloc_valid  = 1'b0;
        bus.alloc_dr_p   = '0;
        bus.alloc_old_dr = '0;
        bus.alloc_pc     = '0;
        bus.cmpl_valid   = '0;
        bus.cmpl_idx     = '0;

        // scenario 1: basic allocate, complete, retire of old_dr 5
        do_reset();
        alloc(32, 5);
        alloc(33, 6);
        cycle(0, 0, 0, 3'b001, 0, 0, 0);
        idle(1);
        check_val("t1_vec", bus.retire_from_ROB, 64'h20);
        check_val("t1_cnt", 64'(bus.retire_cnt), 64'd1);
        complete_all();

        // scenario 2: fill, then an ignored 17th allocation
        do_reset();
        for (int i = 0; i < ROB_DEPTH; i++) alloc(i + 1, i + 10);
        check_val("t2_full", 64'(bus.rob_full), 64'd1);
        alloc(50, 50);
        check_val("t2_num", 64'(bus.rob_num), 64'd0);

        // scenario 3: out-of-order completion retires both together
        cycle(0, 0, 0, 3'b001, 1, 0, 0);
        idle(2);
        cycle(0, 0, 0, 3'b001, 0, 0, 0);
        idle(1);
        check_val("t3_cnt", 64'(bus.retire_cnt), 64'd2);
        check_val("t3_vec", bus.retire_from_ROB, (64'd1 << 10) | (64'd1 << 11));
        complete_all();

        // scenario 4: store (no old mapping) and old_dr 0 free nothing
        do_reset();
        alloc(7, 64);
        cycle(0, 0, 0, 3'b001, 0, 0, 0);
        idle(1);
        check_val("t4_store_vec", bus.retire_from_ROB, 64'd0);
        check_val("t4_store_cnt", 64'(bus.retire_cnt), 64'd1);
        alloc(8, 0);
        cycle(0, 0, 0, 3'b001, 1, 0, 0);
        idle(1);
        check_val("t4_zero_vec", bus.retire_from_ROB, 64'd0);
        check_val("t4_zero_cnt", 64'(bus.retire_cnt), 64'd1);

        // scenario 5: wrap from index 15 to 0
        do_reset();
        for (int i = 0; i < 15; i++) alloc(i, i + 1);
        complete_all();
        alloc(20, 40);
        alloc(21, 41);
        check_val("t5_num", 64'(bus.rob_num), 64'd1);
        cycle(0, 0, 0, 3'b011, 15, 0, 0);
        idle(1);
        check_val("t5_cnt", 64'(bus.retire_cnt), 64'd2);
        idle(1);
        check_val("t5_empty", 64'(bus.rob_empty), 64'd1);

        // scenario 6: reset with entries in flight, stale completion ignored
        for (int i = 0; i < 6; i++) alloc(i, i + 20);
        do_reset();
        cycle(0, 0, 0, 3'b001, 3, 0, 0);
        for (int i = 0; i < 4; i++) alloc(i, i + 30);
        idle(3);
        check_val("t6_cnt", 64'(bus.retire_cnt), 64'd0);
        complete_all();

        // random traffic
        for (int t = 0; t < 3000; t++) begin
            case ($urandom % 8)
                0:       od = 64;
                1:       od = 0;
                default: od = $urandom % 64;
            endcase
            for (int k = 0; k < 3; k++) begin
                cv[k] = ($urandom % 2) == 1;
                if (mq.size() > 0 && ($urandom % 5) != 0)
                    c[k] = mq[$urandom % mq.size()].idx;
                else
                    c[k] = $urandom % ROB_DEPTH;
            end
            cycle(($urandom % 4) != 0, $urandom % 64, od, cv, c[0], c[1], c[2]);
        end
        complete_all();
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
